pc_sequencer: RTL
=================

# pc_sequencer

Multi-cycle program-counter sequencer for the KGPminiRISC core. It owns the PC register and steps each instruction through fetch, decode, execute and PC update. It drives the select input of the next-address mux (26-bit jump immediate, register operand, 16-bit branch label, zero) and decides each cycle whether the PC loads the mux output or increments. It also generates the link-register write for `bl` and stops the machine on a halt instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `PC_INC`, default 32'd1: sequential increment. Instruction memory is word-addressed.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: leave IDLE and begin fetching. Sampled only in IDLE.
- `instr_valid` in 1: decoder outputs valid for the fetched instruction.
- `halt_req` in 1: decoded instruction is `halt`. Qualified by `instr_valid`.
- `br_type` in 4: decoded control class. Encodings:
  - 0 = none
  - 1 = `b`
  - 2 = `br`
  - 3 = `bl`
  - 4 = `bltz`
  - 5 = `bz`
  - 6 = `bnz`
  - 7 = `bcy`
  - 8 = `bncy`
  - 9–15 are reserved and treated as none.
- `flag_sign`, `flag_zero`, `flag_carry` in 1 each: ALU/register flags.
- `target` in 32: output of the next-address mux.
- `addr_sel` out 2: mux select. 00 = imm26, 01 = register, 10 = imm16, 11 = zero.
- `pc` out 32: current PC, registered.
- `fetch_en` out 1: instruction-memory read strobe.
- `pc_we` out 1: PC update strobe, one cycle per retired instruction.
- `link_we` out 1: write `link_addr` to the link register.
- `link_addr` out 32: equals `pc + PC_INC`, valid while `link_we` is high.
- `busy` out 1: high in FETCH, DECODE, EXEC and UPDATE.
- `halted` out 1: high in HALT.

## Operation
- FSM states: IDLE, FETCH, DECODE, EXEC, UPDATE, HALT.
- Transitions:
  - IDLE: stays until `start`=1, then FETCH.
  - FETCH: `fetch_en`=1 for one cycle, then DECODE.
  - DECODE: stalls while `instr_valid`=0. With `instr_valid`=1: if `halt_req`=1 go to HALT (takes priority over `br_type`), otherwise latch `br_type` and go to EXEC.
  - EXEC: `addr_sel` drives the latched class. Flags are sampled at the closing edge into an internal `taken` bit. Next state UPDATE.
  - UPDATE: `pc_we`=1. At the closing edge, `pc` loads `target` if taken, otherwise `pc + PC_INC`. Next state FETCH.
  - HALT: absorbing; only `rst` exits it.
- `addr_sel` mapping, registered and set on entry to EXEC, held through UPDATE, and 11 in all other states:
  - `b`, `bl`, `bcy`, `bncy` → 00
  - `br` → 01
  - `bltz`, `bz`, `bnz` → 10
  - none or reserved → 11 (not used for PC).
- `taken` conditions:
  - `b`, `br`, `bl`: always.
  - `bltz`: `flag_sign`.
  - `bz`: `flag_zero`.
  - `bnz`: !`flag_zero`.
  - `bcy`: `flag_carry`.
  - `bncy`: !`flag_carry`.
  - none or reserved: never.
- `bl`: `link_we`=1 during UPDATE, with `link_addr` = old `pc + PC_INC`.
- Arithmetic: `pc + PC_INC` is 32-bit modulo 2^32. 32'hFFFF_FFFF + 1 wraps to 0 with no flag.
- `target` is used unmodified. The mux performs the zero-extension.
- `start` outside IDLE is ignored. Flag inputs are ignored outside EXEC.

## Timing
- Reset values:
  - `pc` = `RESET_PC`
  - `addr_sel` = 11
  - `fetch_en`, `pc_we`, `link_we`, `busy`, `halted` = 0
  - `link_addr` = `RESET_PC + PC_INC`
  - state = IDLE
- `rst` overrides every other input. Asserted mid-instruction (any state), it yields the reset values at the next edge. No `pc_we` or `link_we` is emitted for the aborted instruction.
- Minimum 4 cycles per instruction (FETCH, DECODE, EXEC, UPDATE). Each DECODE stall cycle adds one cycle.
- `start` high at edge N → `fetch_en` high in cycle N+1.
- The new `pc` is visible in the cycle after UPDATE, which is the next FETCH.
- `target` must be stable during EXEC and UPDATE. It is sampled at the edge closing UPDATE.
- All outputs are Moore, decoded from the state and registers.
- HALT is entered the cycle after DECODE. The PC keeps the address of the halt instruction.

## Test plan
- **Reset/sequential:** reset, `start`, then three instructions with `br_type`=0 and `instr_valid` immediate → `pc` steps 0→1→2→3, `pc_we` pulses 4 cycles apart, `addr_sel`=11 throughout.
- **Conditional branch:** `bz` with `flag_zero`=1, `target`=32'h0000_1234 → `addr_sel`=10 in EXEC/UPDATE, `pc`=0x1234. Repeat with `flag_zero`=0 → `pc`=old+1.
- **Link:** `bl` at `pc`=0x10, `target`=32'h03FF_FFFF → `addr_sel`=00, `link_we`=1 with `link_addr`=0x11 during UPDATE, `pc`=0x03FF_FFFF.
- **Stall and halt:** hold `instr_valid`=0 for 3 cycles in DECODE → no state change. Then `halt_req`=1 with `br_type`=1 → HALT, `halted`=1, `pc` unchanged, `start` ignored.
- **Wrap:** `RESET_PC`=32'hFFFF_FFFF with a sequential instruction → `pc`=0.
- **Reset mid-op:** `rst` during EXEC of a taken `br` (`addr_sel`=01) → next cycle IDLE, `pc`=`RESET_PC`, no `pc_we` pulse.

Source files
------------

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: FETCH -> DECODE -> EXEC -> UPDATE, with branch/link control
// and an absorbing HALT state. All outputs are decoded from state and registers.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        instr_valid,
  input  logic        halt_req,
  input  logic [3:0]  br_type,
  input  logic        flag_sign,
  input  logic        flag_zero,
  input  logic        flag_carry,
  input  logic [31:0] target,
  output logic [1:0]  addr_sel,
  output logic [31:0] pc,
  output logic        fetch_en,
  output logic        pc_we,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic        busy,
  output logic        halted
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, UPDATE, HALT
  } state_t;

  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BR_B    = 4'd1;
  localparam logic [3:0] BR_BR   = 4'd2;
  localparam logic [3:0] BR_BL   = 4'd3;
  localparam logic [3:0] BR_BLTZ = 4'd4;
  localparam logic [3:0] BR_BZ   = 4'd5;
  localparam logic [3:0] BR_BNZ  = 4'd6;
  localparam logic [3:0] BR_BCY  = 4'd7;
  localparam logic [3:0] BR_BNCY = 4'd8;

  localparam logic [1:0] SEL_IMM26 = 2'b00;
  localparam logic [1:0] SEL_REG   = 2'b01;
  localparam logic [1:0] SEL_IMM16 = 2'b10;
  localparam logic [1:0] SEL_ZERO  = 2'b11;

  state_t      state_reg, state_next;
  logic [3:0]  class_reg, class_next;
  logic [1:0]  sel_reg, sel_next;
  logic        taken_reg, taken_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pc_inc;
  logic [1:0]  decoded_sel;

  assign pc_inc = pc_reg + PC_INC;

  // Mux select for the incoming decoded class; reserved encodings fall to zero.
  always_comb begin
    decoded_sel = SEL_ZERO;
    case (br_type)
      BR_B, BR_BL, BR_BCY, BR_BNCY: decoded_sel = SEL_IMM26;
      BR_BR:                        decoded_sel = SEL_REG;
      BR_BLTZ, BR_BZ, BR_BNZ:       decoded_sel = SEL_IMM16;
      default:                      decoded_sel = SEL_ZERO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      class_reg <= BR_NONE;
      sel_reg   <= SEL_ZERO;
      taken_reg <= 1'b0;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      class_reg <= class_next;
      sel_reg   <= sel_next;
      taken_reg <= taken_next;
      pc_reg    <= pc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    class_next = class_reg;
    sel_next   = SEL_ZERO;
    taken_next = taken_reg;
    pc_next    = pc_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        state_next = DECODE;
      end
      DECODE: begin
        if (instr_valid) begin
          if (halt_req) begin
            state_next = HALT;
          end else begin
            state_next = EXEC;
            class_next = (br_type > BR_BNCY) ? BR_NONE : br_type;
            sel_next   = decoded_sel;
          end
        end
      end
      EXEC: begin
        state_next = UPDATE;
        sel_next   = sel_reg;
        case (class_reg)
          BR_B, BR_BR, BR_BL: taken_next = 1'b1;
          BR_BLTZ:            taken_next = flag_sign;
          BR_BZ:              taken_next = flag_zero;
          BR_BNZ:             taken_next = !flag_zero;
          BR_BCY:             taken_next = flag_carry;
          BR_BNCY:            taken_next = !flag_carry;
          default:            taken_next = 1'b0;
        endcase
      end
      UPDATE: begin
        state_next = FETCH;
        pc_next    = taken_reg ? target : pc_inc;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign addr_sel  = sel_reg;
  assign pc        = pc_reg;
  assign link_addr = pc_inc;
  assign fetch_en  = (state_reg == FETCH);
  assign pc_we     = (state_reg == UPDATE);
  assign link_we   = (state_reg == UPDATE) && (class_reg == BR_BL);
  assign busy      = (state_reg == FETCH) || (state_reg == DECODE) ||
                     (state_reg == EXEC)  || (state_reg == UPDATE);
  assign halted    = (state_reg == HALT);

endmodule
